// File: rtl/nibble_serial_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// nibble_serial_adder_ctrl_pkg : shared slice width and controller states
// Revision 1.0
// ============================================================================
package nibble_serial_adder_ctrl_pkg;

    localparam int NIB = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl_cla.sv
`default_nettype none
// ============================================================================
// nibble_serial_adder_ctrl_cla : 4-bit carry-lookahead adder slice
// Revision 1.0
// ============================================================================
module nibble_serial_adder_ctrl_cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Carries flattened from generate/propagate, no ripple between bits.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c[3:0];
    assign co = c[4];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// nibble_serial_adder_ctrl : multi-cycle add/sub streaming nibbles LSB-first
// Revision 1.0
// ============================================================================
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / NIB;
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (N > 1) ? WIDTH - NIB : 1;
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    generate
        if ((WIDTH % NIB) != 0 || WIDTH < NIB) begin : g_width_check
            $error("WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_t           state;
    logic [SW-1:0]    step;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [WW-1:0]    work;
    logic             a_msb;
    logic             b_msb;

    logic [3:0]       nib_sum;
    logic             nib_cout;
    logic [WIDTH-1:0] work_next;
    logic [WW-1:0]    work_d;

    nibble_serial_adder_ctrl_cla u_cla (
        .a  (op_a[NIB-1:0]),
        .b  (op_b[NIB-1:0]),
        .ci (carry),
        .s  (nib_sum),
        .co (nib_cout)
    );

    // Working register holds the upper nibbles already produced; the newest
    // nibble enters at the MSB so after N steps the result is aligned.
    generate
        if (N > 1) begin : g_multi
            assign work_next = {nib_sum, work};
            assign work_d    = work_next[WIDTH-1:NIB];
        end else begin : g_single
            assign work_next = nib_sum;
            assign work_d    = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            step  <= '0;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            work  <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    op_a  <= op_a >> NIB;
                    op_b  <= op_b >> NIB;
                    carry <= nib_cout;
                    work  <= work_d;
                    if (step == LAST) begin
                        step  <= '0;
                        sum   <= work_next;
                        cout  <= nib_cout;
                        ovf   <= (a_msb == b_msb) && (nib_sum[NIB-1] != a_msb);
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        a_msb <= a[WIDTH-1];
                        b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        step  <= '0;
                        work  <= '0;
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// tb_nibble_serial_adder_ctrl : directed self-checking bench, WIDTH=16
// Revision 1.0
// ============================================================================
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Call #1 after a rising edge. Accepts on the next edge, then waits for done.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vcin, input logic vsub,
                          input logic [15:0] esum, input logic ecout, input logic eovf);
        int lat;
        a = va; b = vb; cin = vcin; sub = vsub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = ~vcin; sub = ~vsub;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 4);
        check({tag, "_sum"}, {16'd0, sum}, {16'd0, esum});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ecout});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
        check({tag, "_nobusy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int bcnt;
        int dseen;

        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_flags", {30'd0, cout, ovf}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("t1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("t1_done_pulse", {31'd0, done}, 32'd0);
        run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("t3a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        // issued straight from DONE: back-to-back
        run_op("t3b", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("t4", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("tcin", 16'h00F0, 16'h0F10, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);

        // start re-pulsed mid-RUN must be ignored
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bcnt = 0;
        dseen = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy) bcnt++;
            if (done) dseen++;
            if (i == 1) begin
                a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (i < 5) begin
                @(posedge clk); #1;
            end
        end
        check("t5_busy_cycles", bcnt, 4);
        check("t5_done_cnt", dseen, 1);
        check("t5_sum", {16'd0, sum}, 32'h5555);
        check("t5_flags", {30'd0, cout, ovf}, 32'd0);
        start = 1'b0;

        // async reset during RUN
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_sum", {16'd0, sum}, 32'd0);
        check("t6_flags", {29'd0, done, cout, ovf}, 32'd0);
        dseen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done || busy) dseen++;
        end
        check("t6_quiet", dseen, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("t6_after", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
